pipe_issue_ctrl: RTL and testbench

- Issue/hazard controller for the 8-bit pipelined core. Sits between the IF/ID register and the ID/EX stage.
- Decides each cycle whether the decoded instruction may issue. Drives the shared stall line for fetch and decode.
- Tracks in-flight register writes with a per-register scoreboard.
- Sequences multi-cycle execute ops and pipeline drains.

---
 rtl/cpu_pkg.sv | 22 ++
 rtl/pend_counter.sv | 35 +++
 rtl/pipe_issue_ctrl.sv | 149 ++++++++++++++
 tb/tb_pipe_issue_ctrl.sv | 373 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit core's issue logic: instruction field
// positions, special opcodes and the issue controller's state encoding.
package cpu_pkg;

    localparam int MODE_BIT = 7;
    localparam int OP_MSB   = 6;
    localparam int OP_LSB   = 4;
    localparam int RD_MSB   = 3;
    localparam int RD_LSB   = 2;
    localparam int RS1_MSB  = 1;
    localparam int RS1_LSB  = 0;

    localparam logic [2:0] OP_MUL = 3'b110;
    localparam logic [2:0] OP_NOP = 3'b111;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_MUL   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/pend_counter.sv
// Outstanding-write counter for one architectural register: saturating
// up/down count with a flag for a decrement request against an empty count.
module pend_counter #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic [W-1:0] count_next,
    output logic         underflow
);

    localparam logic [W-1:0] CNT_MAX = '1;
    localparam logic [W-1:0] CNT_ONE = W'(1);

    // Simultaneous inc and dec cancel: the new write replaces the retiring one.
    always_comb begin
        count_next = count;
        if (inc && !dec) begin
            if (count != CNT_MAX) count_next = count + CNT_ONE;
        end else if (dec && !inc) begin
            if (count != '0) count_next = count - CNT_ONE;
        end
    end

    assign underflow = dec && (count == '0);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) count <= '0;
        else         count <= count_next;
    end

endmodule

// File: rtl/pipe_issue_ctrl.sv
// Issue/hazard controller between IF/ID and ID/EX: gates issue on RAW and
// scoreboard-overflow hazards, and sequences multi-cycle ops and drains.
module pipe_issue_ctrl
    import cpu_pkg::*;
#(
    parameter int INSTR_W    = 8,
    parameter int NUM_REGS   = 4,
    parameter int ENC_W      = 2,
    parameter int PEND_W     = 2,
    parameter int MUL_CYCLES = 3,
    parameter int PERF_W     = 16
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                id_valid,
    input  logic [INSTR_W-1:0]  id_instr,
    input  logic                ext_stall,
    input  logic                wb_valid,
    input  logic [ENC_W-1:0]    wb_enc,
    input  logic                drain_req,
    output logic                stall,
    output logic                issue,
    output logic                mul_busy,
    output logic [NUM_REGS-1:0] pending,
    output logic                drain_done,
    output logic                wb_err,
    output logic [PERF_W-1:0]   hazard_cnt
);

    localparam int                MC_W     = $clog2(MUL_CYCLES);
    localparam logic [MC_W-1:0]   MC_LOAD  = MC_W'(MUL_CYCLES - 1);
    localparam logic [MC_W-1:0]   MC_ONE   = MC_W'(1);
    localparam logic [PEND_W-1:0] PEND_MAX = '1;
    localparam logic [PERF_W-1:0] PERF_MAX = '1;
    localparam logic [PERF_W-1:0] PERF_ONE = PERF_W'(1);

    state_t            state;
    logic [MC_W-1:0]   mul_cnt;
    logic              drain_latch;

    logic [2:0]        opcode;
    logic              imm_mode;
    logic              is_nop;
    logic              reads_rs1;
    logic [ENC_W-1:0]  rs0;
    logic [ENC_W-1:0]  rs1;
    logic              raw_haz;
    logic              ovf_haz;
    logic              run_state;
    logic              drain_hold;

    logic [PEND_W-1:0]   cnt      [NUM_REGS];
    logic [PEND_W-1:0]   cnt_next [NUM_REGS];
    logic [NUM_REGS-1:0] inc_v;
    logic [NUM_REGS-1:0] dec_v;
    logic [NUM_REGS-1:0] underflow_v;
    logic [NUM_REGS-1:0] next_zero;

    assign opcode    = id_instr[OP_MSB:OP_LSB];
    assign imm_mode  = id_instr[MODE_BIT];
    assign rs0       = id_instr[RD_MSB:RD_LSB];
    assign rs1       = id_instr[RS1_MSB:RS1_LSB];
    assign is_nop    = (opcode == OP_NOP);
    assign reads_rs1 = !is_nop && !imm_mode;

    // No bypass: a same-cycle writeback has not reached the register file yet.
    assign raw_haz = (!is_nop && pending[rs0]) || (reads_rs1 && pending[rs1]);
    assign ovf_haz = !is_nop && (cnt[rs0] == PEND_MAX);

    assign run_state  = (state == ST_RUN);
    assign drain_hold = drain_req || drain_latch;

    assign stall = ext_stall || raw_haz || ovf_haz || !run_state || drain_hold;
    assign issue = id_valid && !stall;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_pend
        assign inc_v[g] = issue && !is_nop && (rs0 == ENC_W'(g));
        assign dec_v[g] = wb_valid && (wb_enc == ENC_W'(g));

        pend_counter #(
            .W (PEND_W)
        ) u_pend (
            .clk        (clk),
            .resetn     (resetn),
            .inc        (inc_v[g]),
            .dec        (dec_v[g]),
            .count      (cnt[g]),
            .count_next (cnt_next[g]),
            .underflow  (underflow_v[g])
        );

        assign pending[g]   = (cnt[g] != '0);
        assign next_zero[g] = (cnt_next[g] == '0);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= ST_RUN;
            mul_cnt     <= '0;
            drain_latch <= 1'b0;
            mul_busy    <= 1'b0;
            drain_done  <= 1'b0;
        end else begin
            drain_done <= 1'b0;
            case (state)
                ST_RUN: begin
                    if (issue && (opcode == OP_MUL)) begin
                        state    <= ST_MUL;
                        mul_cnt  <= MC_LOAD;
                        mul_busy <= 1'b1;
                    end else if (drain_hold) begin
                        state       <= ST_DRAIN;
                        drain_latch <= 1'b0;
                    end
                end
                ST_MUL: begin
                    // The execute unit keeps counting even under ext_stall.
                    if (drain_req) drain_latch <= 1'b1;
                    mul_cnt <= mul_cnt - MC_ONE;
                    if (mul_cnt == MC_ONE) begin
                        state    <= ST_RUN;
                        mul_busy <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    if (&next_zero) begin
                        state      <= ST_RUN;
                        drain_done <= 1'b1;
                    end
                end
                default: state <= ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)           wb_err <= 1'b0;
        else if (|underflow_v) wb_err <= 1'b1;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hazard_cnt <= '0;
        end else if (id_valid && (raw_haz || ovf_haz) && run_state && (hazard_cnt != PERF_MAX)) begin
            hazard_cnt <= hazard_cnt + PERF_ONE;
        end
    end

endmodule

// File: tb/tb_pipe_issue_ctrl.sv
// Bench for pipe_issue_ctrl: directed scenarios plus a randomized run checked
// against a behavioural model of the scoreboard, multi-cycle op and drain rules.
module tb_pipe_issue_ctrl;

    localparam int MUL_CYCLES = 3;

    logic        clk = 1'b0;
    logic        resetn;
    logic        id_valid;
    logic [7:0]  id_instr;
    logic        ext_stall;
    logic        wb_valid;
    logic [1:0]  wb_enc;
    logic        drain_req;
    logic        stall;
    logic        issue;
    logic        mul_busy;
    logic [3:0]  pending;
    logic        drain_done;
    logic        wb_err;
    logic [15:0] hazard_cnt;

    int checks = 0;
    int errors = 0;

    // Model state: outstanding writes per register, remaining multi-cycle
    // occupancy, whether a drain is running or requested, and the outputs.
    int m_pend [4];
    int m_mul_left;
    bit m_draining;
    bit m_dreq_seen;
    bit m_done;
    bit m_err;
    int m_hcnt;

    pipe_issue_ctrl #(
        .INSTR_W    (8),
        .NUM_REGS   (4),
        .ENC_W      (2),
        .PEND_W     (2),
        .MUL_CYCLES (MUL_CYCLES),
        .PERF_W     (16)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .id_valid   (id_valid),
        .id_instr   (id_instr),
        .ext_stall  (ext_stall),
        .wb_valid   (wb_valid),
        .wb_enc     (wb_enc),
        .drain_req  (drain_req),
        .stall      (stall),
        .issue      (issue),
        .mul_busy   (mul_busy),
        .pending    (pending),
        .drain_done (drain_done),
        .wb_err     (wb_err),
        .hazard_cnt (hazard_cnt)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        for (int r = 0; r < 4; r++) m_pend[r] = 0;
        m_mul_left  = 0;
        m_draining  = 1'b0;
        m_dreq_seen = 1'b0;
        m_done      = 1'b0;
        m_err       = 1'b0;
        m_hcnt      = 0;
    endfunction

    function automatic void model_eval(output bit s, output bit i, output bit hz);
        int op, a, b;
        bit nop, imm;
        op  = int'(id_instr[6:4]);
        a   = int'(id_instr[3:2]);
        b   = int'(id_instr[1:0]);
        nop = (op == 7);
        imm = id_instr[7];
        hz  = !nop && ((m_pend[a] > 0) || (!imm && m_pend[b] > 0) || (m_pend[a] == 3));
        s   = ext_stall || hz || (m_mul_left > 0) || m_draining || drain_req || m_dreq_seen;
        i   = id_valid && !s;
    endfunction

    function automatic void model_update();
        bit s, i, hz, nop, busy, inc, dec, all_zero;
        int op, rd;
        model_eval(s, i, hz);
        op   = int'(id_instr[6:4]);
        rd   = int'(id_instr[3:2]);
        nop  = (op == 7);
        busy = (m_mul_left > 0) || m_draining;
        if (id_valid && hz && !busy && m_hcnt < 65535) m_hcnt++;
        for (int r = 0; r < 4; r++) begin
            inc = i && !nop && (rd == r);
            dec = wb_valid && (int'(wb_enc) == r);
            if (dec && m_pend[r] == 0) m_err = 1'b1;
            if (inc && !dec && m_pend[r] < 3) m_pend[r]++;
            else if (dec && !inc && m_pend[r] > 0) m_pend[r]--;
        end
        all_zero = 1'b1;
        for (int r = 0; r < 4; r++) if (m_pend[r] != 0) all_zero = 1'b0;
        m_done = 1'b0;
        if (m_mul_left > 0) begin
            if (drain_req) m_dreq_seen = 1'b1;
            m_mul_left--;
        end else if (m_draining) begin
            if (all_zero) begin
                m_draining = 1'b0;
                m_done     = 1'b1;
            end
        end else if (i && op == 6) begin
            m_mul_left = MUL_CYCLES - 1;
        end else if (drain_req || m_dreq_seen) begin
            m_draining  = 1'b1;
            m_dreq_seen = 1'b0;
        end
    endfunction

    function automatic logic [3:0] m_pvec();
        logic [3:0] v;
        for (int r = 0; r < 4; r++) v[r] = (m_pend[r] > 0);
        return v;
    endfunction

    task automatic tick();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        id_valid  = 1'b0;
        id_instr  = 8'h70;
        ext_stall = 1'b0;
        wb_valid  = 1'b0;
        wb_enc    = 2'd0;
        drain_req = 1'b0;
    endtask

    task automatic retire(input logic [1:0] r);
        id_valid = 1'b0;
        wb_valid = 1'b1;
        wb_enc   = r;
        #1;
        tick();
        wb_valid = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        checks++; if (stall !== 1'b0)       begin errors++; $display("FAIL rst_stall got=%b want=0", stall); end
        checks++; if (issue !== 1'b0)       begin errors++; $display("FAIL rst_issue got=%b want=0", issue); end
        checks++; if (mul_busy !== 1'b0)    begin errors++; $display("FAIL rst_mul_busy got=%b want=0", mul_busy); end
        checks++; if (pending !== 4'b0)     begin errors++; $display("FAIL rst_pending got=%b want=0000", pending); end
        checks++; if (drain_done !== 1'b0)  begin errors++; $display("FAIL rst_drain_done got=%b want=0", drain_done); end
        checks++; if (wb_err !== 1'b0)      begin errors++; $display("FAIL rst_wb_err got=%b want=0", wb_err); end
        checks++; if (hazard_cnt !== 16'd0) begin errors++; $display("FAIL rst_hazard_cnt got=%0d want=0", hazard_cnt); end
        @(posedge clk);
        #2 resetn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_raw();
        id_valid = 1'b1;
        id_instr = 8'h04;
        #1;
        checks++; if (issue !== 1'b1) begin errors++; $display("FAIL raw_first_issue got=%b want=1", issue); end
        tick();
        id_instr = 8'h05;
        #1;
        checks++; if (stall !== 1'b1)       begin errors++; $display("FAIL raw_stall got=%b want=1", stall); end
        checks++; if (issue !== 1'b0)       begin errors++; $display("FAIL raw_no_issue got=%b want=0", issue); end
        checks++; if (pending !== 4'b0010)  begin errors++; $display("FAIL raw_pending got=%b want=0010", pending); end
        checks++; if (hazard_cnt !== 16'd0) begin errors++; $display("FAIL raw_hcnt0 got=%0d want=0", hazard_cnt); end
        tick();
        checks++; if (hazard_cnt !== 16'd1) begin errors++; $display("FAIL raw_hcnt1 got=%0d want=1", hazard_cnt); end
        tick();
        wb_valid = 1'b1;
        wb_enc   = 2'd1;
        #1;
        checks++; if (stall !== 1'b1)       begin errors++; $display("FAIL raw_wb_same_cycle got=%b want=1", stall); end
        checks++; if (hazard_cnt !== 16'd2) begin errors++; $display("FAIL raw_hcnt2 got=%0d want=2", hazard_cnt); end
        tick();
        wb_valid = 1'b0;
        #1;
        checks++; if (stall !== 1'b0)       begin errors++; $display("FAIL raw_released got=%b want=0", stall); end
        checks++; if (issue !== 1'b1)       begin errors++; $display("FAIL raw_issue got=%b want=1", issue); end
        checks++; if (hazard_cnt !== 16'd3) begin errors++; $display("FAIL raw_hcnt3 got=%0d want=3", hazard_cnt); end
        tick();
        retire(2'd1);
    endtask

    task automatic test_imm();
        id_valid = 1'b1;
        id_instr = 8'h0C;
        #1;
        tick();
        id_instr = 8'h03;
        #1;
        checks++; if (pending !== 4'b1000) begin errors++; $display("FAIL imm_pending got=%b want=1000", pending); end
        checks++; if (stall !== 1'b1)      begin errors++; $display("FAIL imm_reg_rs1_stall got=%b want=1", stall); end
        tick();
        id_instr = 8'h83;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL imm_stall got=%b want=0", stall); end
        checks++; if (issue !== 1'b1) begin errors++; $display("FAIL imm_issue got=%b want=1", issue); end
        tick();
        retire(2'd0);
        retire(2'd3);
    endtask

    task automatic test_mul();
        id_valid = 1'b1;
        id_instr = 8'h60;
        #1;
        checks++; if (issue !== 1'b1) begin errors++; $display("FAIL mul_issue got=%b want=1", issue); end
        tick();
        id_instr = 8'h09;
        #1;
        checks++; if (mul_busy !== 1'b1) begin errors++; $display("FAIL mul_busy_c1 got=%b want=1", mul_busy); end
        checks++; if (stall !== 1'b1)    begin errors++; $display("FAIL mul_stall_c1 got=%b want=1", stall); end
        checks++; if (issue !== 1'b0)    begin errors++; $display("FAIL mul_issue_c1 got=%b want=0", issue); end
        tick();
        ext_stall = 1'b1;
        #1;
        checks++; if (mul_busy !== 1'b1) begin errors++; $display("FAIL mul_busy_c2 got=%b want=1", mul_busy); end
        checks++; if (stall !== 1'b1)    begin errors++; $display("FAIL mul_stall_c2 got=%b want=1", stall); end
        tick();
        ext_stall = 1'b0;
        #1;
        checks++; if (mul_busy !== 1'b0) begin errors++; $display("FAIL mul_busy_c3 got=%b want=0", mul_busy); end
        checks++; if (issue !== 1'b1)    begin errors++; $display("FAIL mul_issue_c3 got=%b want=1", issue); end
        tick();
        retire(2'd0);
        retire(2'd2);
    endtask

    task automatic test_same_dest();
        id_valid = 1'b1;
        id_instr = 8'h28;
        #1;
        checks++; if (issue !== 1'b1) begin errors++; $display("FAIL dest_first got=%b want=1", issue); end
        tick();
        #1;
        checks++; if (stall !== 1'b1)      begin errors++; $display("FAIL dest_stall got=%b want=1", stall); end
        checks++; if (pending !== 4'b0100) begin errors++; $display("FAIL dest_pending got=%b want=0100", pending); end
        tick();
        wb_valid = 1'b1;
        wb_enc   = 2'd2;
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL dest_wb_cycle got=%b want=1", stall); end
        tick();
        wb_valid = 1'b0;
        #1;
        checks++; if (issue !== 1'b1) begin errors++; $display("FAIL dest_reissue got=%b want=1", issue); end
        tick();
        retire(2'd2);
    endtask

    task automatic test_drain();
        id_valid = 1'b1;
        id_instr = 8'h04;
        #1;
        tick();
        id_instr = 8'h08;
        #1;
        tick();
        id_instr  = 8'h70;
        drain_req = 1'b1;
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL drain_req_stall got=%b want=1", stall); end
        checks++; if (issue !== 1'b0) begin errors++; $display("FAIL drain_req_issue got=%b want=0", issue); end
        tick();
        #1;
        checks++; if (stall !== 1'b1)      begin errors++; $display("FAIL drain_hold got=%b want=1", stall); end
        checks++; if (drain_done !== 1'b0) begin errors++; $display("FAIL drain_early_done got=%b want=0", drain_done); end
        tick();
        drain_req = 1'b0;
        wb_valid  = 1'b1;
        wb_enc    = 2'd1;
        #1;
        tick();
        wb_enc = 2'd2;
        #1;
        checks++; if (drain_done !== 1'b0) begin errors++; $display("FAIL drain_done_wb2 got=%b want=0", drain_done); end
        checks++; if (stall !== 1'b1)      begin errors++; $display("FAIL drain_stall_wb2 got=%b want=1", stall); end
        tick();
        wb_valid = 1'b0;
        #1;
        checks++; if (drain_done !== 1'b1) begin errors++; $display("FAIL drain_done got=%b want=1", drain_done); end
        checks++; if (issue !== 1'b1)      begin errors++; $display("FAIL drain_resume got=%b want=1", issue); end
        tick();
        checks++; if (drain_done !== 1'b0) begin errors++; $display("FAIL drain_pulse_len got=%b want=0", drain_done); end
        id_valid = 1'b0;
    endtask

    task automatic test_async_reset_err();
        id_valid = 1'b1;
        id_instr = 8'h60;
        #1;
        tick();
        idle_inputs();
        #2;
        resetn = 1'b0;
        #1;
        model_reset();
        checks++; if (mul_busy !== 1'b0) begin errors++; $display("FAIL arst_mul_busy got=%b want=0", mul_busy); end
        checks++; if (pending !== 4'b0)  begin errors++; $display("FAIL arst_pending got=%b want=0000", pending); end
        checks++; if (stall !== 1'b0)    begin errors++; $display("FAIL arst_stall got=%b want=0", stall); end
        checks++; if (hazard_cnt !== 16'd0) begin errors++; $display("FAIL arst_hcnt got=%0d want=0", hazard_cnt); end
        #2 resetn = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (drain_done !== 1'b0) begin errors++; $display("FAIL arst_no_done got=%b want=0", drain_done); end
        wb_valid = 1'b1;
        wb_enc   = 2'd0;
        #1;
        checks++; if (wb_err !== 1'b0) begin errors++; $display("FAIL err_before got=%b want=0", wb_err); end
        tick();
        wb_valid = 1'b0;
        #1;
        checks++; if (wb_err !== 1'b1) begin errors++; $display("FAIL err_set got=%b want=1", wb_err); end
        tick();
        tick();
        checks++; if (wb_err !== 1'b1) begin errors++; $display("FAIL err_sticky got=%b want=1", wb_err); end
        checks++; if (pending !== 4'b0) begin errors++; $display("FAIL err_pending got=%b want=0000", pending); end
    endtask

    task automatic test_random();
        bit es, ei, eh;
        int enc;
        for (int n = 0; n < 600; n++) begin
            id_valid  = ($urandom_range(0, 3) != 0);
            id_instr  = 8'($urandom);
            ext_stall = ($urandom_range(0, 9) == 0);
            drain_req = ($urandom_range(0, 29) == 0);
            enc       = int'($urandom_range(0, 3));
            wb_enc    = 2'(enc);
            wb_valid  = (m_pend[enc] > 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 49) == 0);
            #1;
            model_eval(es, ei, eh);
            checks++; if (stall !== es)        begin errors++; $display("FAIL rnd_stall n=%0d got=%b want=%b", n, stall, es); end
            checks++; if (issue !== ei)        begin errors++; $display("FAIL rnd_issue n=%0d got=%b want=%b", n, issue, ei); end
            checks++; if (mul_busy !== (m_mul_left > 0)) begin errors++; $display("FAIL rnd_mul_busy n=%0d got=%b want=%b", n, mul_busy, (m_mul_left > 0)); end
            checks++; if (pending !== m_pvec()) begin errors++; $display("FAIL rnd_pending n=%0d got=%b want=%b", n, pending, m_pvec()); end
            checks++; if (drain_done !== m_done) begin errors++; $display("FAIL rnd_drain_done n=%0d got=%b want=%b", n, drain_done, m_done); end
            checks++; if (wb_err !== m_err)    begin errors++; $display("FAIL rnd_wb_err n=%0d got=%b want=%b", n, wb_err, m_err); end
            checks++; if (hazard_cnt !== 16'(m_hcnt)) begin errors++; $display("FAIL rnd_hcnt n=%0d got=%0d want=%0d", n, hazard_cnt, m_hcnt); end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        resetn = 1'b0;
        idle_inputs();
        model_reset();
        test_reset();
        test_raw();
        test_imm();
        test_mul();
        test_same_dest();
        test_drain();
        test_async_reset_err();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
